ro_freq_counter: RTL and testbench
==================================

RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 Parameter CNT_W, default 16, width of the edge count result.
REQ-002 Parameter WIN_W, default 16, width of the measurement-window length input.
REQ-003 Parameter SETTLE, default 4, number of clk cycles the ring is enabled before counting starts (must be >= 1).
REQ-004 Port clk  input  1  single system clock; all flops are on its rising edge.
REQ-005 Port rst_n  input  1  synchronous, active-low reset.
REQ-006 Port start  input  1  request one measurement; sampled only in IDLE.
REQ-007 Port win_len  input  WIN_W  window length in clk cycles; captured when start is accepted.
REQ-008 Port ro_in  input  1  asynchronous ring-oscillator output.
REQ-009 Port ro_en  output  1  ring-oscillator enable, driving the oscillator's enable input.
REQ-010 Port busy  output  1  high while a measurement is in progress.
REQ-011 Port done  output  1  one-cycle pulse when count and overflow are valid.
REQ-012 Port count  output  CNT_W  number of ro_in rising edges seen in the last window.
REQ-013 Port overflow  output  1  set if the last window's edge total exceeded 2^CNT_W-1.

Function
REQ-014 FSM states SHALL be IDLE, ARM, MEAS and DONE.
REQ-015 Transitions SHALL be:
- IDLE->ARM on start=1.
- ARM->MEAS after SETTLE cycles in ARM.
- MEAS->DONE after win_len cycles in MEAS.
- MEAS SHALL be skipped (ARM->DONE) when win_len=0.
- DONE->IDLE after one cycle.
REQ-016 With start accepted in cycle T, ro_en=1 and busy=1 from T+1 through the last MEAS cycle, and done=1 exactly in cycle T+1+SETTLE+win_len.
REQ-017 start SHALL be ignored in ARM, MEAS and DONE; no queuing.
REQ-018 ro_in SHALL pass through a 2-flop synchronizer plus one history flop; rise = sync2 & ~hist.
REQ-019 A rise pulse SHALL increment the internal counter only in a cycle whose state is MEAS; rises in ARM, DONE or IDLE are discarded.
REQ-020 The internal counter and overflow flag SHALL clear on entry to ARM.
REQ-021 count and overflow SHALL update in the DONE cycle and hold until the next DONE or reset.
REQ-022 overflow SHALL be set when an increment occurs at counter value 2^CNT_W-1, and is sticky for the window.
REQ-023 Input ro_in frequency SHALL be below clk/2 for exact counts; faster inputs alias and are not flagged.

Reset
REQ-024 On rst_n=0 at a clk edge: state=IDLE; ro_en, busy, done, overflow = 0; count = 0; synchronizer and history flops = 0.
REQ-025 Reset asserted mid-measurement SHALL abort it: ro_en=0 in the cycle after the reset edge, and no done pulse.

Configuration
REQ-026 Macro RO_SAT_EN SHALL select the counter's overflow behaviour.
- Defined: the counter saturates at 2^CNT_W-1.
- Undefined: the counter wraps modulo 2^CNT_W.
- overflow behaves identically in both cases.

Structure
REQ-027 Package ro_pkg SHALL hold the FSM state enum and the default CNT_W, WIN_W and SETTLE constants.
REQ-028 Sub-module ro_sync_edge SHALL hold the synchronizer, history flop and rise detector; it is clocked by clk and reset by rst_n.

Verification
REQ-029 Test 1: ro_in square wave of period 8 clk, win_len=64, start pulse -> done at T+69; count=8; overflow=0.
REQ-030 Test 2: win_len=0 -> ro_en high T+1..T+4; done at T+5; count=0.
REQ-031 Test 3: CNT_W=4, ro_in period 4, win_len=100 (25 edges) -> overflow=1; count=15 with RO_SAT_EN, 9 without.
REQ-032 Test 4: start held high continuously, win_len=16 -> back-to-back measurements, each done spaced 22 cycles apart; starts during busy have no effect.
REQ-033 Test 5: rst_n=0 in the 10th MEAS cycle -> ro_en=0 and busy=0 next cycle; count=0; no done pulse.
REQ-034 Test 6: ro_in toggling only during ARM, static during MEAS -> count=0.

Source files
------------

// File: rtl/ro_pkg.sv
// rtl/ro_pkg.sv - shared FSM state type and default sizing for the ring-oscillator counter
package ro_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    DONE
  } ro_state_e;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_WIN_W  = 16;
  localparam int DEF_SETTLE = 4;

endpackage

// File: rtl/ro_sync_edge.sv
// rtl/ro_sync_edge.sv - two-flop synchronizer plus history flop giving a one-cycle rise pulse
module ro_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= ro_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~hist_q;

endmodule

// File: rtl/ro_freq_counter.sv
// rtl/ro_freq_counter.sv - ring-oscillator edge counter over a programmable window; RO_SAT_EN selects saturating counter
module ro_freq_counter
  import ro_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN_W  = DEF_WIN_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // One timer serves both the settle phase and the window, so it must hold either bound.
  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = (WIN_W > SW) ? WIN_W : SW;
  localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  ro_state_e        state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_out_q, ovf_out_d;
  logic             rise;

  ro_sync_edge u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .ro_i   (ro_in),
    .rise_o (rise)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    ovf_out_d = ovf_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          win_d   = win_len;
          tmr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ARM: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d   = '0;
          state_d = (win_q == '0) ? DONE : MEAS;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      MEAS: begin
        if (rise) begin
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
`ifdef RO_SAT_EN
            cnt_d = CNT_MAX;
`else
            cnt_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (tmr_q == TW'(win_q) - TW'(1)) begin
          state_d = DONE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Latch the result on entry to DONE so it already includes the last MEAS cycle's rise.
    if (state_q != DONE && state_d == DONE) begin
      count_d   = cnt_d;
      ovf_out_d = ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign ro_en    = (state_q == ARM) || (state_q == MEAS);
  assign busy     = ro_en;
  assign done     = (state_q == DONE);
  assign count    = count_q;
  assign overflow = ovf_out_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// tb/tb_ro_freq_counter.sv - directed-vector bench for ro_freq_counter (expects RO_SAT_EN as built)
module tb_ro_freq_counter;

  localparam int CNT_W  = 4;
  localparam int WIN_W  = 16;
  localparam int SETTLE = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic             ro_in = 1'b0;
  logic             ro_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int   n_vec = 0;
  int   n_miss = 0;
  int   ro_per = 0;
  int   ro_ph = 0;
  logic ro_lvl = 1'b0;

  ro_freq_counter #(
    .CNT_W  (CNT_W),
    .WIN_W  (WIN_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .win_len  (win_len),
    .ro_in    (ro_in),
    .ro_en    (ro_en),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Oscillator stand-in: square wave of period ro_per clk cycles, or static ro_lvl when ro_per is 0.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ro_per == 0) begin
        ro_in = ro_lvl;
      end else begin
        ro_ph = (ro_ph + 1) % ro_per;
        ro_in = (ro_ph < ro_per / 2);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Returns latency from the accept cycle T to done (done in cycle T+lat), ro_en-high cycle count,
  // and ro_en/busy as seen in T+1. pulse_at>0 drives a single high cycle on ro_in at T+pulse_at.
  task automatic run_meas(input int wl, input int pulse_at, output int lat, output int en_cyc,
                          output logic en_first, output logic busy_first);
    @(posedge clk); #1;
    start   = 1'b1;
    win_len = WIN_W'(wl);
    @(posedge clk); #1;
    start      = 1'b0;
    lat        = 1;
    en_cyc     = 0;
    en_first   = ro_en;
    busy_first = busy;
    while (!done && lat < 1000) begin
      if (pulse_at > 0) ro_lvl = (lat == pulse_at);
      if (ro_en) en_cyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int   lat, en_cyc, k, seen;
  int   d_cyc[3];
  logic en_first, busy_first;
  logic [31:0] exp_sat;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ro_en", ro_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    // Test 1: period 8, window 64
    ro_per = 8;
    run_meas(64, 0, lat, en_cyc, en_first, busy_first);
    check("t1_latency", lat, 69);
    check("t1_ro_en_first", en_first, 1);
    check("t1_busy_first", busy_first, 1);
    check("t1_ro_en_cycles", en_cyc, 68);
    check("t1_count", count, 8);
    check("t1_overflow", overflow, 0);
    @(posedge clk); #1;
    check("t1_done_width", done, 0);

    // Test 6: one ro_in pulse in ARM, static through MEAS
    ro_per = 0;
    ro_lvl = 1'b0;
    repeat (4) @(posedge clk);
    run_meas(16, 1, lat, en_cyc, en_first, busy_first);
    ro_lvl = 1'b0;
    check("t6_latency", lat, 21);
    check("t6_count", count, 0);
    check("t6_overflow", overflow, 0);

    // Test 3: period 4, window 100 -> 25 edges into a 4-bit counter
    ro_per = 4;
    run_meas(100, 0, lat, en_cyc, en_first, busy_first);
`ifdef RO_SAT_EN
    exp_sat = 15;
`else
    exp_sat = 9;
`endif
    check("t3_latency", lat, 105);
    check("t3_count", count, exp_sat);
    check("t3_overflow", overflow, 1);

    // Test 2: zero-length window skips MEAS
    run_meas(0, 0, lat, en_cyc, en_first, busy_first);
    check("t2_latency", lat, 5);
    check("t2_ro_en_cycles", en_cyc, 4);
    check("t2_ro_en_first", en_first, 1);
    check("t2_count", count, 0);
    check("t2_overflow", overflow, 0);

    // Test 4: start held high, back-to-back measurements
    ro_per = 8;
    @(posedge clk); #1;
    start   = 1'b1;
    win_len = WIN_W'(16);
    k = 0;
    seen = 0;
    while (seen < 3 && k < 300) begin
      @(posedge clk); #1;
      k++;
      if (done) begin
        d_cyc[seen] = k;
        seen++;
      end
    end
    start = 1'b0;
    check("t4_done_seen", seen, 3);
    check("t4_spacing_a", d_cyc[1] - d_cyc[0], 22);
    check("t4_spacing_b", d_cyc[2] - d_cyc[1], 22);
    check("t4_count", count, 2);
    repeat (3) @(posedge clk);

    // Test 5: reset in the 10th MEAS cycle aborts the measurement
    @(posedge clk); #1;
    start   = 1'b1;
    win_len = WIN_W'(64);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("t5_ro_en_before", ro_en, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t5_ro_en", ro_en, 0);
    check("t5_busy", busy, 0);
    check("t5_count", count, 0);
    check("t5_overflow", overflow, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("t5_no_done", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
